// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: single-outstanding data-memory request/response bus
// master (access unit) drives dmem_read/dmem_write/dmem_address/dmem_wdata/dmem_mbe;
// slave (memory) returns dmem_rdata together with the one-cycle dmem_resp pulse.
interface dmem_access_unit_if #(parameter int ADDR_WIDTH = 32);
    logic                  dmem_read;
    logic                  dmem_write;
    logic [ADDR_WIDTH-1:0] dmem_address;
    logic [31:0]           dmem_wdata;
    logic [3:0]            dmem_mbe;
    logic [31:0]           dmem_rdata;
    logic                  dmem_resp;
    modport master(output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
                   input dmem_rdata, dmem_resp);
    modport slave(input dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
                  output dmem_rdata, dmem_resp);
endinterface

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store unit driving a single-outstanding data-memory port
// Ports: clk, rst (async, active-high); pipeline side mem_valid, flush, data_read, data_write,
// store_len, load_funct3, mem_addr, store_data -> stall, load_data, load_valid, misaligned;
// memory side via bus (dmem_access_unit_if.master).
// Optional: define DMEM_MISALIGN_TRAP_EN to reject misaligned accesses with a misaligned pulse.
module dmem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  flush,
    input  logic                  data_read,
    input  logic                  data_write,
    input  logic [3:0]            store_len,
    input  logic [2:0]            load_funct3,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           store_data,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  misaligned,
    dmem_access_unit_if.master    bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state;
    logic        is_store;
    logic        squash;
    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic        req;
    logic        mis;
    logic        accept;
    logic        busy;
    logic [31:0] shifted;
    logic [31:0] extended;
    assign req  = mem_valid & !flush & (data_read | data_write);
    assign busy = state == BUSY;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic half;
    logic word;
    assign half = data_write ? store_len == 4'b0011 : (load_funct3 == 3'b001 || load_funct3 == 3'b101);
    assign word = data_write ? store_len == 4'b1111 : load_funct3 == 3'b010;
    assign mis  = !rst & !busy & req & ((half & mem_addr[0]) | (word & |mem_addr[1:0]));
`else
    assign mis  = 1'b0;
`endif
    assign accept     = !busy & req & !mis;
    assign misaligned = mis;
    // Gated with rst so the unit looks fully quiet while reset is held.
    assign stall      = !rst & (accept | (busy & !bus.dmem_resp));
    // A flush arriving in the response cycle squashes the load as well.
    assign load_valid = !rst & busy & bus.dmem_resp & !is_store & !squash & !flush;
    assign shifted    = bus.dmem_rdata >> {offset, 3'b000};
    assign extended   = funct3 == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]} :
                        funct3 == 3'b100 ? {24'b0, shifted[7:0]} :
                        funct3 == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]} :
                        funct3 == 3'b101 ? {16'b0, shifted[15:0]} : shifted;
    assign load_data  = load_valid ? extended : 32'b0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            bus.dmem_read    <= 1'b0;
            bus.dmem_write   <= 1'b0;
            bus.dmem_address <= '0;
            bus.dmem_wdata   <= '0;
            bus.dmem_mbe     <= '0;
            is_store         <= 1'b0;
            squash           <= 1'b0;
            funct3           <= '0;
            offset           <= '0;
        end else if (!busy) begin
            if (accept) begin
                state            <= BUSY;
                bus.dmem_read    <= !data_write;
                bus.dmem_write   <= data_write;
                bus.dmem_address <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                bus.dmem_wdata   <= store_data << {mem_addr[1:0], 3'b000};
                bus.dmem_mbe     <= store_len << mem_addr[1:0];
                is_store         <= data_write;
                squash           <= 1'b0;
                funct3           <= load_funct3;
                offset           <= mem_addr[1:0];
            end
        end else begin
            if (flush)
                squash <= 1'b1;
            if (bus.dmem_resp) begin
                state          <= IDLE;
                bus.dmem_read  <= 1'b0;
                bus.dmem_write <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: table-driven and randomized checks of dmem_access_unit against a byte-level model
module tb_dmem_access_unit;
    logic        clk = 0;
    logic        rst = 1;
    logic        mem_valid = 0, flush = 0, data_read = 0, data_write = 0;
    logic [3:0]  store_len = 0;
    logic [2:0]  load_funct3 = 0;
    logic [31:0] mem_addr = 0, store_data = 0;
    logic        stall, load_valid, misaligned;
    logic [31:0] load_data;
    int          checks = 0, failures = 0;

    dmem_access_unit_if #(.ADDR_WIDTH(32)) bus ();

    dmem_access_unit #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .flush(flush),
        .data_read(data_read), .data_write(data_write), .store_len(store_len),
        .load_funct3(load_funct3), .mem_addr(mem_addr), .store_data(store_data),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .misaligned(misaligned), .bus(bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr, rd;
        logic [3:0]  len;
        logic [2:0]  f3;
        logic [31:0] addr, sd, rdata;
        int          lat;
        logic        fl;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_mbe;
        logic        e_lv;
        logic [31:0] e_ld;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    function automatic vec_t mk(logic wr, logic rd, logic [3:0] len, logic [2:0] f3,
                                logic [31:0] addr, logic [31:0] sd, logic [31:0] rdata, int lat, logic fl,
                                logic [31:0] e_addr, logic [3:0] e_mbe, logic [31:0] e_wdata,
                                logic e_lv, logic [31:0] e_ld);
        vec_t v;
        v.wr = wr; v.rd = rd; v.len = len; v.f3 = f3; v.addr = addr; v.sd = sd; v.rdata = rdata;
        v.lat = lat; v.fl = fl; v.e_addr = e_addr; v.e_mbe = e_mbe; v.e_wdata = e_wdata;
        v.e_lv = e_lv; v.e_ld = e_ld;
        return v;
    endfunction

    // Byte-lane model: place each byte at lane (i + offset), drop what falls off lane 3.
    function automatic vec_t model(vec_t v);
        int          off = int'(v.addr[1:0]);
        int          w;
        bit          sgn;
        longint      val;
        logic [31:0] sh;
        v.e_addr = v.addr & 32'hFFFF_FFFC;
        v.e_mbe = 0;
        v.e_wdata = 0;
        for (int i = 0; i < 4; i++)
            if (i + off < 4) begin
                v.e_mbe[i + off] = v.len[i];
                v.e_wdata[8*(i + off) +: 8] = v.sd[8*i +: 8];
            end
        sh = v.rdata >> (8 * off);
        case (v.f3)
            3'b000: begin w = 8;  sgn = 1; end
            3'b100: begin w = 8;  sgn = 0; end
            3'b001: begin w = 16; sgn = 1; end
            3'b101: begin w = 16; sgn = 0; end
            default: begin w = 32; sgn = 0; end
        endcase
        val = longint'(sh) % (64'd1 << w);
        if (sgn && val >= (64'd1 << (w - 1)))
            val = val - (64'd1 << w);
        v.e_ld = val[31:0];
        v.e_lv = v.rd && !v.wr && !v.fl;
        return v;
    endfunction

    function automatic bit is_mis(vec_t v);
        bit half = v.wr ? v.len == 4'b0011 : (v.f3 == 3'b001 || v.f3 == 3'b101);
        bit word = v.wr ? v.len == 4'b1111 : v.f3 == 3'b010;
        return (half && v.addr[0]) || (word && v.addr[1:0] != 0);
    endfunction

    task automatic run(input vec_t v, input string tag);
        @(posedge clk); #1;
        mem_valid = 1; flush = 0; data_read = v.rd; data_write = v.wr; store_len = v.len;
        load_funct3 = v.f3; mem_addr = v.addr; store_data = v.sd; bus.dmem_resp = 0;
        @(negedge clk);
        chk({tag, " acc_stall"}, 32'(stall), 1);
        chk({tag, " acc_read"}, 32'(bus.dmem_read), 0);
        chk({tag, " acc_mis"}, 32'(misaligned), 0);
        @(posedge clk); #1;
        for (int i = 0; i <= v.lat; i++) begin
            flush = v.fl && i == 0;
            bus.dmem_resp = i == v.lat;
            bus.dmem_rdata = i == v.lat ? v.rdata : 32'hDEAD_BEEF;
            @(negedge clk);
            chk({tag, " read"}, 32'(bus.dmem_read), 32'(!v.wr));
            chk({tag, " write"}, 32'(bus.dmem_write), 32'(v.wr));
            chk({tag, " addr"}, bus.dmem_address, v.e_addr);
            chk({tag, " mbe"}, 32'(bus.dmem_mbe), 32'(v.e_mbe));
            chk({tag, " wdata"}, bus.dmem_wdata, v.e_wdata);
            chk({tag, " stall"}, 32'(stall), 32'(i != v.lat));
            chk({tag, " lvalid"}, 32'(load_valid), 32'(i == v.lat && v.e_lv));
            chk({tag, " ldata"}, load_data, (i == v.lat && v.e_lv) ? v.e_ld : 32'h0);
            @(posedge clk); #1;
        end
        mem_valid = 0; flush = 0; bus.dmem_resp = 0;
        @(negedge clk);
        chk({tag, " done_read"}, 32'(bus.dmem_read | bus.dmem_write), 0);
        chk({tag, " done_stall"}, 32'(stall), 0);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        bus.dmem_resp = 0;
        bus.dmem_rdata = 0;
`ifndef DMEM_MISALIGN_TRAP_EN
        tbl.push_back(mk(1, 0, 4'hF, 3'b010, 32'h1000_0006, 32'hAABB_CCDD, 0, 2, 0,
                         32'h1000_0004, 4'b1100, 32'hCCDD_0000, 0, 0));
`endif
        tbl.push_back(mk(0, 1, 4'h1, 3'b000, 32'h2003, 0, 32'h80FF_1234, 3, 0, 32'h2000, 4'b1000, 0, 1, 32'hFFFF_FF80));
        tbl.push_back(mk(0, 1, 4'h1, 3'b100, 32'h2003, 0, 32'h80FF_1234, 3, 0, 32'h2000, 4'b1000, 0, 1, 32'h0000_0080));
        tbl.push_back(mk(0, 1, 4'h3, 3'b001, 32'h2002, 0, 32'h8001_0000, 1, 0, 32'h2000, 4'b1100, 0, 1, 32'hFFFF_8001));
        tbl.push_back(mk(0, 1, 4'h3, 3'b101, 32'h2002, 0, 32'h8001_0000, 1, 0, 32'h2000, 4'b1100, 0, 1, 32'h0000_8001));
        tbl.push_back(mk(1, 0, 4'h1, 3'b000, 32'h11, 32'h5A, 0, 0, 0, 32'h10, 4'b0010, 32'h0000_5A00, 0, 0));
        tbl.push_back(mk(0, 1, 4'hF, 3'b010, 32'h40, 0, 32'h1234_5678, 2, 1, 32'h40, 4'b1111, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'hF, 3'b010, 32'h44, 0, 32'hCAFE_BABE, 0, 0, 32'h44, 4'b1111, 0, 1, 32'hCAFE_BABE));
        tbl.push_back(mk(1, 1, 4'h3, 3'b000, 32'h102, 32'h1234, 0, 1, 0, 32'h100, 4'b1100, 32'h1234_0000, 0, 0));

        #2;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_read", 32'(bus.dmem_read | bus.dmem_write), 0);
        chk("rst_addr", bus.dmem_address, 0);
        chk("rst_wdata", bus.dmem_wdata, 0);
        chk("rst_mbe", 32'(bus.dmem_mbe), 0);
        chk("rst_lvalid", 32'(load_valid), 0);
        chk("rst_ldata", load_data, 0);
        chk("rst_mis", 32'(misaligned), 0);
        @(posedge clk); #1;
        rst = 0;

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // Flush in IDLE: no request accepted.
        @(posedge clk); #1;
        mem_valid = 1; flush = 1; data_read = 1; data_write = 0; load_funct3 = 3'b010; mem_addr = 32'h80;
        @(negedge clk);
        chk("idle_flush_stall", 32'(stall), 0);
        @(posedge clk); #1;
        mem_valid = 0; flush = 0;
        @(negedge clk);
        chk("idle_flush_read", 32'(bus.dmem_read), 0);

        // Stray response in IDLE is ignored.
        bus.dmem_resp = 1; bus.dmem_rdata = 32'h7777_7777;
        #1;
        chk("stray_lvalid", 32'(load_valid), 0);
        chk("stray_stall", 32'(stall), 0);
        @(posedge clk); #1;
        bus.dmem_resp = 0;

        // Reset mid-transaction abandons it.
        mem_valid = 1; data_read = 1; data_write = 0; store_len = 4'hF; load_funct3 = 3'b010; mem_addr = 32'h200;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_busy_read", 32'(bus.dmem_read), 1);
        #1 rst = 1;
        #1;
        chk("mid_rst_read", 32'(bus.dmem_read), 0);
        chk("mid_rst_stall", 32'(stall), 0);
        chk("mid_rst_addr", bus.dmem_address, 0);
        @(posedge clk); #1;
        mem_valid = 0; rst = 0;
        bus.dmem_resp = 1; bus.dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("post_rst_lvalid", 32'(load_valid), 0);
        chk("post_rst_ldata", load_data, 0);
        chk("post_rst_stall", 32'(stall), 0);
        @(posedge clk); #1;
        bus.dmem_resp = 0;

`ifdef DMEM_MISALIGN_TRAP_EN
        mem_valid = 1; data_read = 1; data_write = 0; store_len = 4'hF; load_funct3 = 3'b010; mem_addr = 32'h3002;
        @(negedge clk);
        chk("trap_mis", 32'(misaligned), 1);
        chk("trap_stall", 32'(stall), 0);
        chk("trap_lvalid", 32'(load_valid), 0);
        @(posedge clk); #1;
        mem_valid = 0;
        @(negedge clk);
        chk("trap_read", 32'(bus.dmem_read), 0);
        chk("trap_mis_drop", 32'(misaligned), 0);
`endif

        for (int n = 0; n < 60; n++) begin
            int sel = $urandom_range(0, 2);
            int fs = $urandom_range(0, 5);
            v.wr = $urandom_range(0, 1);
            v.rd = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
            v.len = sel == 0 ? 4'h1 : sel == 1 ? 4'h3 : 4'hF;
            v.f3 = fs == 0 ? 3'b000 : fs == 1 ? 3'b001 : fs == 2 ? 3'b010 :
                   fs == 3 ? 3'b100 : fs == 4 ? 3'b101 : 3'b011;
            v.addr = $urandom;
            v.sd = $urandom;
            v.rdata = $urandom;
            v.lat = $urandom_range(0, 3);
            v.fl = $urandom_range(0, 3) == 0;
`ifdef DMEM_MISALIGN_TRAP_EN
            if (is_mis(v)) v.addr[1:0] = 2'b00;
`else
            if (is_mis(v) && v.lat == 0) v.lat = 1;
`endif
            v = model(v);
            run(v, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
